// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART responder on the core's uart port.
// Registers: CTRL {overrun, tx_ready, rx_valid}, RX data, TX data.
package uart_pkg;

    typedef enum int {
        BR_9600   = 9600,
        BR_19200  = 19200,
        BR_57600  = 57600,
        BR_115200 = 115200,
        BR_921600 = 921600
    } uart_baud_rate_t;

    typedef struct packed {
        logic       en;
        logic       we;
        logic       load_signed;
        logic [1:0] addr;
    } uart_ctrl_t;

    localparam logic [1:0] UART_CTRL = 2'd0;
    localparam logic [1:0] UART_RX   = 2'd1;
    localparam logic [1:0] UART_TX   = 2'd2;

endpackage

module uart_periph
    import uart_pkg::*;
#(
    parameter int              CLK_FREQ_HZ = 100_000_000,
    parameter uart_baud_rate_t BAUD_RATE   = BR_115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  uart_ctrl_t ctrl,
    input  logic [7:0] send,
    output logic [7:0] recv,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / int'(BAUD_RATE);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_periph: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} fsm_e;

    fsm_e          tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    fsm_e          rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          rx_done;

    logic [7:0]    recv_q, recv_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;

    logic rd, rd_ctrl, rd_rx, tx_ready, tx_start;
    logic unused_load_signed;

    assign unused_load_signed = ctrl.load_signed;
    assign rd       = ctrl.en & ~ctrl.we;
    assign rd_ctrl  = rd & (ctrl.addr == UART_CTRL);
    assign rd_rx    = rd & (ctrl.addr == UART_RX);
    assign tx_ready = (tx_state_q == S_IDLE);
    assign tx_start = ctrl.en & ctrl.we & (ctrl.addr == UART_TX) & tx_ready;
    assign recv     = recv_q;
    assign uart_tx  = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_state_d = S_START;
                    tx_shift_d = send;
                end
            end
            S_START: if (tx_cnt_q == BIT_END) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end
            S_DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            S_STOP: if (tx_cnt_q == BIT_END) begin
                tx_state_d = S_IDLE;
                tx_cnt_d   = '0;
            end
        endcase
    end

    // Line level follows the next state so uart_tx stays registered.
    always_comb begin
        tx_d = 1'b1;
        unique case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_shift_d[tx_bit_d];
            S_IDLE,
            S_STOP:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        unique case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q & ~rx_sync_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == HALF_END) begin
                rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
            end
            S_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == BIT_END) begin
                rx_state_d = S_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rx_done = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_END) && rx_sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recv_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            recv_q     <= recv_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // A completing byte beats a same-cycle read-clear of the flags.
    always_comb begin
        recv_d = recv_q;
        if (rd) begin
            unique case (ctrl.addr)
                UART_CTRL: recv_d = {5'b0, overrun_q, tx_ready, rx_valid_q};
                UART_RX:   recv_d = rx_data_q;
                default:   recv_d = 8'h00;
            endcase
        end
        rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_done | (rx_valid_q & ~rd_rx);
        overrun_d  = (rx_done & rx_valid_q & ~rd_rx) | (overrun_q & ~rd_ctrl);
    end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
- Memory-mapped 8N1 UART on the peripheral (RX-modport) side of the core's uart interface; it is the responder to the core's load/store accesses.
- Serializes bytes the core writes to the TX register onto a line output.
- Deserializes the line input into the RX register and exposes status through the CTRL register.
- Sits at the SoC top level between the core's uart port and the board pins.

Parameters:
- CLK_FREQ_HZ, 100_000_000, core clock frequency.
- BAUD_RATE, BR_115200 (uart_baud_rate_t), line rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (localparam, 868 at defaults), baud tick period in clocks. Elaboration fails if below 4.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- ctrl  input  5  uart_ctrl_t {en, we, load_signed, addr[1:0]}: access strobe from core
- send  input  8  write data for store accesses
- recv  output  8  read data, registered
- uart_rx  input  1  serial line in, asynchronous to clk
- uart_tx  output  1  serial line out, idles high

Behaviour:
- Reset values: uart_tx=1, recv=0, rx_valid=0, overrun=0, rx_data=0, TX FSM=IDLE, RX FSM=IDLE, all counters 0.
- Access decode:
  - An access occurs when ctrl.en=1.
  - ctrl.we=1 is a write; ctrl.we=0 is a read.
  - ctrl.load_signed is ignored here; the core performs the extension.
- Reads: recv updates one cycle after the access (1-cycle load latency). recv holds its value when there is no read.
  - UART_CTRL returns {5'b0, overrun, tx_ready, rx_valid}, then clears overrun.
  - UART_RX returns rx_data, then clears rx_valid.
  - UART_TX and addr 3 return 8'h00.
- Writes:
  - UART_TX with tx_ready=1 latches send and starts a frame.
  - UART_TX with tx_ready=0 is dropped silently.
  - Writes to CTRL, RX or addr 3 are ignored.
- tx_ready = (TX FSM == IDLE). It drops the cycle after an accepted TX write.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA drives bits 0..7, LSB first, CLKS_PER_BIT cycles each, with a 3-bit bit index.
  - STOP drives 1 for CLKS_PER_BIT cycles.
  - A frame is 10*CLKS_PER_BIT cycles from the first START cycle to IDLE.
  - uart_tx is registered.
- RX input path: uart_rx passes through a 2-flop synchronizer. The FSM uses only the synchronized value.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge (sync 1->0) enters START.
  - START: wait CLKS_PER_BIT/2 cycles. If the line is high at that point, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting LSB first, for 8 bits.
  - STOP: sample at mid-bit.
    - If high: rx_data <= shift register, and rx_valid <= 1. If rx_valid was already 1, also set overrun=1; the new byte overwrites.
    - If low: framing error, byte discarded, no flag change.
  - From STOP, return to IDLE and re-arm on the next falling edge.
- Simultaneous events:
  - A RX read in the same cycle a byte completes: recv gets the old rx_data. Set wins, so rx_valid stays 1 and no overrun is flagged.
  - A CTRL read in the same cycle overrun is set: the read returns the old value and overrun ends up 1.
- Reset mid-frame: asynchronous. uart_tx goes high immediately, both FSMs return to IDLE, and any partial byte is lost.
- TX and RX are fully independent, so full-duplex works.

Test Plan (CLK_FREQ_HZ=14_745_600, BAUD_RATE=BR_921600, so CLKS_PER_BIT=16):
- Write TX 8'hA5 -> uart_tx drives 0 for 16 clk, then bits 1,0,1,0,0,1,0,1 (16 clk each), then 1 for 16 clk. tx_ready=0 for exactly 160 clk. A CTRL read mid-frame returns 8'h00.
- Write TX 8'h3C, then write TX 8'hFF 20 cycles later -> only 8'h3C appears on the line. The second write is dropped and the line idles high after 160 clk.
- Drive a frame of 8'h5A on uart_rx -> CTRL read returns 8'h03 (tx idle, rx_valid). RX read returns 8'h5A on recv 1 cycle later. A following CTRL read returns 8'h02.
- Drive 8'h11 then 8'h22 with no reads -> CTRL read returns 8'h07 and the next CTRL read returns 8'h03. RX read returns 8'h22.
- Drive an 8-cycle low glitch on uart_rx, then a frame of 8'h81 whose stop bit is held low -> rx_valid stays 0. A following valid frame of 8'h81 sets rx_valid and RX read returns 8'h81.
- Assert rst_n=0 mid TX frame at bit 3 -> uart_tx=1 in the same cycle. After release, CTRL read returns 8'h02 and a new TX write of 8'h00 transmits correctly.
